// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction-fetch prefetch queue.
// Holds the fetch FSM encoding, the decoder step codes and the halfword type.
package ifetch_pkg;

  typedef enum logic [0:0] {
    IF_IDLE = 1'b0,
    IF_REQ  = 1'b1
  } if_state_e;

  typedef logic [15:0] hword_t;

  localparam logic [1:0] STEP_NONE = 2'd0;
  localparam logic [1:0] STEP_ONE  = 2'd1;
  localparam logic [1:0] STEP_TWO  = 2'd2;

  // The decoder never consumes more than two halfwords, so code 3 acts as 2.
  function automatic logic [1:0] clamp_step(input logic [1:0] step);
    return (step == 2'd3) ? STEP_TWO : step;
  endfunction

endpackage

// File: rtl/ifetch_queue_hword_ring.sv
// Circular halfword buffer: two read ports at head/head+1, writes of 1 or 2
// halfwords at tail, pops of 0/1/2 at head, and a flush that empties it.
module hword_ring
  import ifetch_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic [1:0]               wr_cnt,
  input  hword_t                   wr_data0,
  input  hword_t                   wr_data1,
  input  logic [1:0]               pop_cnt,
  output hword_t                   rd_data0,
  output hword_t                   rd_data1,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  hword_t        mem_q [DEPTH];
  hword_t        mem_d [DEPTH];
  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [AW-1:0] head_nxt;
  logic [AW:0]   count_q, count_d;

  always_comb begin
    mem_d = mem_q;
    if (!flush) begin
      if (wr_cnt != STEP_NONE) mem_d[tail_q] = wr_data0;
      if (wr_cnt == STEP_TWO) mem_d[tail_q + AW'(1)] = wr_data1;
    end
  end

  // Pointers wrap naturally because they are exactly log2(DEPTH) bits wide.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      head_d  = head_q + AW'(pop_cnt);
      tail_d  = tail_q + AW'(wr_cnt);
      count_d = count_q - (AW+1)'(pop_cnt) + (AW+1)'(wr_cnt);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign head_nxt = head_q + AW'(1);
  assign rd_data0 = mem_q[head_q];
  assign rd_data1 = mem_q[head_nxt];
  assign count    = count_q;

endmodule

// File: rtl/ifetch_queue.sv
// Instruction-fetch prefetch queue: issues aligned 32-bit reads, buffers the
// halfwords and presents a 32-bit window to the decoder, with redirect/flush.
module ifetch_queue
  import ifetch_pkg::*;
#(
  parameter int          DEPTH    = 8,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ifRedirect,
  input  logic [31:0] ifNewPc,
  input  logic        ifAdvance,
  input  logic [1:0]  idStepPc,
  output logic [31:0] istrWord,
  output logic        ifValid,
  output logic [31:0] ifPc,
  output logic        memReq,
  output logic [31:0] memAddr,
  input  logic        memAck,
  input  logic [31:0] memData
);

  localparam int          AW       = $clog2(DEPTH);
  localparam logic [AW:0] MIN_FILL = (AW+1)'(2);

  if_state_e   state_q, state_d;
  logic [31:0] fpc_q, fpc_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] addr_q, addr_d;
  logic        discard_q, discard_d;
  logic [AW:0] count;
  logic [AW:0] free;
  logic [1:0]  wr_cnt, pop_cnt;
  hword_t      wr_data0, wr_data1, rd_data0, rd_data1;
  logic [31:0] new_pc;
  logic        accept;

  assign new_pc = ifNewPc & ~32'd1;
  assign free   = (AW+1)'(DEPTH) - count;
  assign accept = (state_q == IF_REQ) && memAck;

  always_ff @(posedge clk) begin
    if (reset) state_q <= IF_IDLE;
    else       state_q <= state_d;
  end

  // A redirect in IDLE waits one cycle so the request uses the new fetch PC.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IF_IDLE: if (!ifRedirect && free >= MIN_FILL) state_d = IF_REQ;
      IF_REQ:  if (memAck) state_d = IF_IDLE;
      default: state_d = IF_IDLE;
    endcase
  end

  always_comb begin
    memReq   = (state_q == IF_REQ);
    memAddr  = addr_q;
    ifValid  = (count >= MIN_FILL);
    ifPc     = pc_q;
    istrWord = ifValid ? {rd_data1, rd_data0} : 32'd0;
  end

  always_comb begin
    fpc_d     = fpc_q;
    addr_d    = addr_q;
    discard_d = discard_q;
    wr_cnt    = STEP_NONE;
    wr_data0  = memData[15:0];
    wr_data1  = memData[31:16];
    pop_cnt   = STEP_NONE;
    if (ifAdvance && ifValid) pop_cnt = clamp_step(idStepPc);
    pc_d = pc_q + {29'd0, pop_cnt, 1'b0};
    if (state_q == IF_IDLE && state_d == IF_REQ) addr_d = {fpc_q[31:2], 2'b00};
    if (accept) begin
      discard_d = 1'b0;
      if (!discard_q && !ifRedirect) begin
        fpc_d = {fpc_q[31:2], 2'b00} + 32'd4;
        if (fpc_q[1]) begin
          wr_cnt   = STEP_ONE;
          wr_data0 = memData[31:16];
        end else begin
          wr_cnt = STEP_TWO;
        end
      end
    end
    // Redirect wins over pop and enqueue; an in-flight read becomes stale.
    if (ifRedirect) begin
      fpc_d     = new_pc;
      pc_d      = new_pc;
      pop_cnt   = STEP_NONE;
      wr_cnt    = STEP_NONE;
      discard_d = (state_q == IF_REQ) && !memAck;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fpc_q     <= RESET_PC;
      pc_q      <= RESET_PC;
      addr_q    <= '0;
      discard_q <= 1'b0;
    end else begin
      fpc_q     <= fpc_d;
      pc_q      <= pc_d;
      addr_q    <= addr_d;
      discard_q <= discard_d;
    end
  end

  hword_ring #(
    .DEPTH(DEPTH)
  ) u_ring (
    .clk      (clk),
    .reset    (reset),
    .flush    (ifRedirect),
    .wr_cnt   (wr_cnt),
    .wr_data0 (wr_data0),
    .wr_data1 (wr_data1),
    .pop_cnt  (pop_cnt),
    .rd_data0 (rd_data0),
    .rd_data1 (rd_data1),
    .count    (count)
  );

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue: a memory responder plus a PC model that
// predicts ifPc and the expected instruction window from memory contents.
module tb_ifetch_queue;
  import ifetch_pkg::*;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        ifRedirect;
  logic [31:0] ifNewPc;
  logic        ifAdvance;
  logic [1:0]  idStepPc;
  logic [31:0] istrWord;
  logic        ifValid;
  logic [31:0] ifPc;
  logic        memReq;
  logic [31:0] memAddr;
  logic        memAck;
  logic [31:0] memData;

  int          pass_count;
  int          check_count;
  logic        auto_ack;
  logic [31:0] exp_pc;

  always #5 clk = ~clk;

  ifetch_queue #(
    .DEPTH    (8),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .ifRedirect (ifRedirect),
    .ifNewPc    (ifNewPc),
    .ifAdvance  (ifAdvance),
    .idStepPc   (idStepPc),
    .istrWord   (istrWord),
    .ifValid    (ifValid),
    .ifPc       (ifPc),
    .memReq     (memReq),
    .memAddr    (memAddr),
    .memAck     (memAck),
    .memData    (memData)
  );

  // Low addresses hold 1111,2222,3333,...; higher ones hold C<addr[11:0]>.
  function automatic logic [15:0] hw_at(input logic [31:0] a);
    logic [15:0] k;
    if (a < 32'd16) begin
      k = {13'd0, a[3:1]} + 16'd1;
      return 16'h1111 * k;
    end
    return {4'hC, a[11:0]};
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {hw_at(a + 32'd2), hw_at(a)};
  endfunction

  function automatic logic [31:0] byte_step(input logic [1:0] s);
    case (s)
      2'd0:    return 32'd0;
      2'd1:    return 32'd2;
      default: return 32'd4;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    check_count++;
    if (observed === expected) pass_count++;
    else $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
  endtask

  // One clock with the given decoder/redirect inputs; redirect is a pulse.
  task automatic applyStimulus(input logic adv, input logic [1:0] step,
                               input logic redir, input logic [31:0] npc);
    logic was_valid;
    ifAdvance  = adv;
    idStepPc   = step;
    ifRedirect = redir;
    ifNewPc    = npc;
    was_valid  = ifValid;
    @(posedge clk);
    if (reset)                      exp_pc = RESET_PC;
    else if (ifRedirect)            exp_pc = ifNewPc & ~32'd1;
    else if (was_valid && ifAdvance) exp_pc = exp_pc + byte_step(idStepPc);
    #1;
    ifRedirect = 1'b0;
    if (auto_ack) begin
      if (memReq && !memAck) begin
        memAck  = 1'b1;
        memData = mem_word(memAddr);
      end else begin
        memAck = 1'b0;
      end
    end
  endtask

  task automatic checkWindow(input string tag);
    checkOutput({tag, "_pc"}, ifPc, exp_pc);
    if (ifValid) checkOutput({tag, "_win"}, istrWord, mem_word(exp_pc) & 32'hFFFF_FFFF
                             ^ ((exp_pc[1]) ? (mem_word(exp_pc) ^ {hw_at(exp_pc + 32'd2), hw_at(exp_pc)}) : 32'd0));
  endtask

  task automatic waitReq(input string tag, input int budget);
    int n;
    n = 0;
    while (!memReq && n < budget) begin
      applyStimulus(1'b0, STEP_NONE, 1'b0, 32'd0);
      n++;
    end
    if (!memReq) checkOutput({tag, "_req_timeout"}, {31'd0, memReq}, 32'd1);
  endtask

  task automatic waitValid(input string tag, input int budget);
    int n;
    n = 0;
    while (!ifValid && n < budget) begin
      applyStimulus(1'b0, STEP_NONE, 1'b0, 32'd0);
      n++;
    end
    if (!ifValid) checkOutput({tag, "_valid_timeout"}, {31'd0, ifValid}, 32'd1);
  endtask

  initial begin
    reset       = 1'b1;
    ifRedirect  = 1'b0;
    ifNewPc     = 32'd0;
    ifAdvance   = 1'b0;
    idStepPc    = STEP_NONE;
    memAck      = 1'b0;
    memData     = 32'd0;
    auto_ack    = 1'b1;
    exp_pc      = RESET_PC;
    pass_count  = 0;
    check_count = 0;

    repeat (3) applyStimulus(1'b0, STEP_NONE, 1'b0, 32'd0);
    checkOutput("reset_valid", {31'd0, ifValid}, 32'd0);
    checkOutput("reset_req", {31'd0, memReq}, 32'd0);
    checkOutput("reset_pc", ifPc, RESET_PC);

    // First fetch after reset, then a single-halfword pop.
    reset = 1'b0;
    applyStimulus(1'b0, STEP_NONE, 1'b0, 32'd0);
    checkOutput("first_req", {31'd0, memReq}, 32'd1);
    checkOutput("first_addr", memAddr, 32'h0000_0000);
    applyStimulus(1'b0, STEP_NONE, 1'b0, 32'd0);
    checkOutput("first_valid", {31'd0, ifValid}, 32'd1);
    checkOutput("first_win", istrWord, 32'h2222_1111);
    checkOutput("first_pc", ifPc, 32'h0000_0000);
    applyStimulus(1'b0, STEP_NONE, 1'b0, 32'd0);
    checkOutput("second_addr", memAddr, 32'h0000_0004);
    applyStimulus(1'b0, STEP_NONE, 1'b0, 32'd0);
    applyStimulus(1'b1, STEP_ONE, 1'b0, 32'd0);
    checkOutput("step1_win", istrWord, 32'h3333_2222);
    checkOutput("step1_pc", ifPc, 32'h0000_0002);

    // Steady consumption; code 3 in the second half must behave as 2.
    for (int i = 0; i < 40; i++) begin
      applyStimulus(1'b1, (i < 20) ? STEP_TWO : 2'd3, 1'b0, 32'd0);
      checkWindow("steady");
    end
    checkOutput("steady_progress", {31'd0, (exp_pc >= 32'd40)}, 32'd1);

    // Stalled consumer fills the queue and fetching stops.
    for (int i = 0; i < 16; i++) begin
      applyStimulus((i >= 8), STEP_NONE, 1'b0, 32'd0);
      checkWindow("stall");
    end
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, STEP_NONE, 1'b0, 32'd0);
      checkOutput("stall_req", {31'd0, memReq}, 32'd0);
    end
    checkOutput("stall_valid", {31'd0, ifValid}, 32'd1);
    applyStimulus(1'b1, STEP_TWO, 1'b0, 32'd0);
    checkOutput("pop_req_low", {31'd0, memReq}, 32'd0);
    checkWindow("pop");
    applyStimulus(1'b0, STEP_NONE, 1'b0, 32'd0);
    checkOutput("pop_req_high", {31'd0, memReq}, 32'd1);
    applyStimulus(1'b0, STEP_NONE, 1'b0, 32'd0);

    // Redirect to 0x40, then redirect again to 0x102 while 0x40 is in flight.
    auto_ack = 1'b0;
    memAck   = 1'b0;
    applyStimulus(1'b0, STEP_NONE, 1'b1, 32'h0000_0040);
    checkOutput("redir1_valid", {31'd0, ifValid}, 32'd0);
    checkOutput("redir1_pc", ifPc, 32'h0000_0040);
    waitReq("redir1", 8);
    checkOutput("outstanding_addr", memAddr, 32'h0000_0040);
    applyStimulus(1'b0, STEP_NONE, 1'b1, 32'h0000_0103);
    checkOutput("hold_req", {31'd0, memReq}, 32'd1);
    checkOutput("hold_addr", memAddr, 32'h0000_0040);
    checkOutput("redir2_pc", ifPc, 32'h0000_0102);
    checkOutput("redir2_valid", {31'd0, ifValid}, 32'd0);
    repeat (2) applyStimulus(1'b0, STEP_NONE, 1'b0, 32'd0);
    checkOutput("hold_addr2", memAddr, 32'h0000_0040);
    memAck  = 1'b1;
    memData = mem_word(32'h0000_0040);
    applyStimulus(1'b0, STEP_NONE, 1'b0, 32'd0);
    memAck  = 1'b0;
    checkOutput("stale_dropped", {31'd0, ifValid}, 32'd0);
    checkOutput("stale_req", {31'd0, memReq}, 32'd0);
    auto_ack = 1'b1;
    waitReq("refetch", 8);
    checkOutput("refetch_addr", memAddr, 32'h0000_0100);
    applyStimulus(1'b0, STEP_NONE, 1'b0, 32'd0);
    checkOutput("half_only", {31'd0, ifValid}, 32'd0);

    auto_ack = 1'b0;
    memAck   = 1'b0;
    waitReq("mis2", 8);
    checkOutput("mis2_addr", memAddr, 32'h0000_0104);
    memAck  = 1'b1;
    memData = mem_word(32'h0000_0104);
    applyStimulus(1'b0, STEP_NONE, 1'b0, 32'd0);
    memAck  = 1'b0;
    checkOutput("mis_valid", {31'd0, ifValid}, 32'd1);
    checkOutput("mis_low", {16'd0, istrWord[15:0]}, 32'h0000_C102);
    checkOutput("mis_win", istrWord, 32'hC104_C102);
    checkOutput("mis_pc", ifPc, 32'h0000_0102);

    // Redirect coinciding with memAck and a decoder pop.
    waitReq("coinc", 8);
    checkOutput("coinc_pre_addr", memAddr, 32'h0000_0108);
    memAck  = 1'b1;
    memData = mem_word(32'h0000_0108);
    applyStimulus(1'b1, STEP_TWO, 1'b1, 32'h0000_0200);
    memAck  = 1'b0;
    checkOutput("coinc_valid", {31'd0, ifValid}, 32'd0);
    checkOutput("coinc_pc", ifPc, 32'h0000_0200);
    checkOutput("coinc_req", {31'd0, memReq}, 32'd0);
    auto_ack = 1'b1;
    waitReq("coinc_next", 8);
    checkOutput("coinc_addr", memAddr, 32'h0000_0200);
    applyStimulus(1'b0, STEP_NONE, 1'b0, 32'd0);
    checkOutput("coinc_no_discard", {31'd0, ifValid}, 32'd1);
    checkOutput("coinc_win", istrWord, 32'hC202_C200);

    // Reset while a request is outstanding, followed by a stray ack.
    auto_ack = 1'b0;
    memAck   = 1'b0;
    waitReq("rst", 8);
    reset = 1'b1;
    applyStimulus(1'b0, STEP_NONE, 1'b0, 32'd0);
    reset = 1'b0;
    checkOutput("rst_req", {31'd0, memReq}, 32'd0);
    checkOutput("rst_valid", {31'd0, ifValid}, 32'd0);
    checkOutput("rst_pc", ifPc, RESET_PC);
    memAck  = 1'b1;
    memData = 32'hDEAD_BEEF;
    applyStimulus(1'b1, STEP_ONE, 1'b0, 32'd0);
    memAck  = 1'b0;
    checkOutput("stray_ignored", {31'd0, ifValid}, 32'd0);
    checkOutput("rst_refetch_req", {31'd0, memReq}, 32'd1);
    checkOutput("rst_refetch_addr", memAddr, RESET_PC);
    checkOutput("adv_ignored", ifPc, RESET_PC);
    memAck  = 1'b1;
    memData = mem_word(RESET_PC);
    applyStimulus(1'b1, STEP_ONE, 1'b0, 32'd0);
    memAck  = 1'b0;
    checkOutput("rst_data_valid", {31'd0, ifValid}, 32'd1);
    checkOutput("rst_data_win", istrWord, 32'h2222_1111);
    checkOutput("rst_data_pc", ifPc, RESET_PC);
    applyStimulus(1'b0, STEP_NONE, 1'b0, 32'd0);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule

// File: doc/ifetch_queue.md
Name: ifetch_queue

Overview:
- Instruction-fetch prefetch queue directly upstream of the instruction decoder.
- Issues 32-bit aligned reads to the instruction memory port and buffers the returned 16-bit halfwords in a circular queue.
- Presents a 32-bit instruction window to the decoder: first word in [15:0], second word in [31:16].
- Pops 1 or 2 halfwords per cycle as directed by the decoder's step count; flushes and refetches on a PC redirect.

Parameters:
- DEPTH, 8, queue capacity in halfwords; power of two, >= 4.
- RESET_PC, 32'h0000_0000, fetch PC after reset; halfword aligned.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- ifRedirect  in  1  flush the queue and restart fetch at ifNewPc.
- ifNewPc  in  32  redirect target; bit 0 is ignored (forced 0).
- ifAdvance  in  1  decoder consumed the current window this cycle.
- idStepPc  in  2  halfwords consumed: 1 or 2; 0 means no pop; 3 is treated as 2.
- istrWord  out  32  instruction window {q[head+1], q[head]}.
- ifValid  out  1  count >= 2; istrWord is fully valid.
- ifPc  out  32  byte address of q[head].
- memReq  out  1  read request; held high until memAck.
- memAddr  out  32  request address; bits [1:0] = 0; held stable while memReq.
- memAck  in  1  one-cycle response strobe; memData valid this cycle.
- memData  in  32  [15:0] = halfword at memAddr, [31:16] = halfword at memAddr+2.

Behaviour:
- Reset (synchronous, dominates all inputs):
  - count=0, head=tail=0, ifValid=0, memReq=0, discard=0.
  - ifPc=RESET_PC; fetch PC fpc=RESET_PC.
  - istrWord=0 while count<2; it is don't-care, but the bench checks it only when ifValid=1.
- Reset mid-request: memReq drops the next cycle. A memAck arriving after reset with no request outstanding is ignored.
- Fetch FSM states:
  - IDLE: go to REQ when free (DEPTH-count) >= 2.
  - REQ: memReq=1, memAddr={fpc[31:2],2'b00}. On memAck: go to IDLE, fpc=(fpc&~3)+4.
  - Exactly one request outstanding; memReq stays asserted while waiting for memAck.
- memReq rises the cycle after the IDLE->REQ decision.
- Response handling:
  - Enqueue memData[15:0] then memData[31:16] (count+=2).
  - If fpc[1]=1 (first fetch after a misaligned redirect), enqueue only memData[31:16] (count+=1).
  - Data written on memAck cycle N is visible on istrWord/ifValid at cycle N+1.
- Pop: when ifAdvance && ifValid, head+=step, count-=step, ifPc+=2*step.
  - ifAdvance while !ifValid is ignored.
  - step 0 means no pop.
- Simultaneous pop and enqueue in the same cycle: count = count - step + enq. No stall.
- The free-space check uses the registered count, so overflow is impossible.
- Redirect (priority over pop and enqueue):
  - Next cycle: count=0, head=tail=0, ifValid=0, ifPc=fpc={ifNewPc[31:1],1'b0}.
  - If a request is outstanding: set discard. The matching memAck is dropped and clears discard; the FSM then returns to IDLE and refetches at the new fpc.
  - If a redirect coincides with memAck, that data is dropped and discard is not set.
  - Back-to-back redirects: the last one wins. discard stays a single bit because only one request is ever outstanding.
- Wrap-around: head/tail are log2(DEPTH) bits and wrap modulo DEPTH; q[head+1] also wraps.
- Full: count=DEPTH-1 or DEPTH blocks new requests until pops free 2 slots.
- All outputs are registered or decoded from registers only; there are no combinational paths from inputs to outputs.

Decomposition:
- Shared package ifetch_pkg: fetch FSM state encoding (IF_IDLE, IF_REQ), STEP_NONE/STEP_ONE/STEP_TWO constants, the halfword type.
- One natural sub-module: hword_ring (DEPTH x 16 circular buffer with dual read port head/head+1, 1-or-2 write, 0/1/2 pop, count output). The fetch FSM, PC and discard logic live in the top.

Test Plan:
- Reset then run: memory returns 32'h2222_1111 @0 and 32'h4444_3333 @4, memAck 1 cycle after memReq -> ifValid at cycle 3, istrWord=32'h2222_1111, ifPc=0; after step=1, istrWord=32'h3333_2222, ifPc=2.
- Steady consumption with step=2 every cycle, DEPTH=8, ack latency 1 -> no enqueue or pop loss; ifPc sequence 0,4,8,...; count never exceeds 8.
- Stall consumer (ifAdvance=0) -> memReq stops once count>=7; then a single step=2 pop leads to memReq reasserting 1 cycle later.
- Redirect to 32'h0000_0102 while a request to 0x40 is outstanding -> ack for 0x40 dropped; next memAddr=0x100; only the upper halfword is enqueued; istrWord[15:0] = mem[0x102] once ifValid; ifPc=0x102.
- Redirect on the same cycle as memAck and ifAdvance -> queue empty next cycle, no enqueue, no pop, no discard left pending.
- Assert reset while memReq=1 for 1 cycle, then memAck 2 cycles later -> ack ignored; fetch restarts at RESET_PC; ifValid=0 until the new data arrives.
